// File: rtl/mem_burst_ctrl_pkg.sv
// Shared definitions for the burst controller and the memory it drives:
// default geometry, FSM state encoding and the command-length legality rule.
package mem_burst_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // A burst must move at least one word and may not revisit any location.
    function automatic bit len_is_legal(input int len, input int depth);
        return (len >= 1) && (len <= depth);
    endfunction

endpackage

// File: rtl/mem_burst_addr_gen.sv
// Address and beat bookkeeping for one burst: a loadable address counter that
// wraps modulo DEPTH, plus issued/acknowledged beat counters with end flags.
module mem_burst_addr_gen
    import mem_burst_ctrl_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic                  issue_i,
    input  logic                  ack_i,
    output logic [ADDR_WIDTH-1:0] cur_addr_o,
    output logic                  issue_done_o,
    output logic                  ack_last_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    // Counters are one bit wider than the address so len == DEPTH fits.
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued_q;
    logic [ADDR_WIDTH:0]   acked_q;
    logic [ADDR_WIDTH-1:0] addr_d;

    // Next address with explicit wrap, so a non-power-of-two DEPTH also works.
    always_comb begin
        addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    end

    // Load on command accept, then step per issued / acknowledged beat.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            acked_q  <= '0;
        end else if (load_i) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            addr_q   <= start_addr_i;
            len_q    <= len_i;
            issued_q <= '0;
            acked_q  <= '0;
        end else begin
            if (issue_i) begin
                addr_q   <= addr_d;
                issued_q <= issued_q + CNT_ONE;
            end
            if (ack_i) begin
                acked_q <= acked_q + CNT_ONE;
            end
        end
    end

    assign cur_addr_o   = addr_q;
    assign issue_done_o = (issued_q == len_q);
    assign ack_last_o   = ((acked_q + CNT_ONE) == len_q);

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst master in front of the single-port memory: takes one command
// (address, length, direction) from the host and turns it into a stream of
// single-beat valid/ready requests, forwarding write data in and read data out.
module mem_burst_ctrl
    import mem_burst_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic [WIDTH-1:0]      s_wdata,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [WIDTH-1:0]      m_rdata,
    output logic                  m_rvalid,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_wr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata
);

    state_e                state_q;
    logic                  mem_valid_q;
    logic                  mem_wr_rd_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0]      mem_wdata_q;
    logic [WIDTH-1:0]      m_rdata_q;
    logic                  m_rvalid_q;
    logic                  done_q;
    logic                  err_q;

    logic                  cmd_legal;
    logic                  load;
    logic                  mem_hs;
    logic                  slot_free;
    logic                  in_burst;
    logic                  wr_fire;
    logic                  rd_issue;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  issue_done;
    logic                  ack_last;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign cmd_legal = len_is_legal(int'(cmd_len), DEPTH);
    assign load      = cmd_ready && cmd_valid && cmd_legal;

    // The request register may be refilled when empty or when it is being
    // consumed this cycle; this is what gives one beat per cycle.
    assign mem_hs    = mem_valid_q && mem_ready;
    assign slot_free = !mem_valid_q || mem_ready;
    assign in_burst  = (state_q == ST_WR) || (state_q == ST_RD);

    assign s_wready  = (state_q == ST_WR) && !issue_done && slot_free;
    assign wr_fire   = s_wready && s_wvalid;
    assign rd_issue  = (state_q == ST_RD) && !issue_done && slot_free;
    assign issue     = wr_fire || rd_issue;

    mem_burst_addr_gen #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk          (clk),
        .res          (res),
        .load_i       (load),
        .start_addr_i (cmd_addr),
        .len_i        (cmd_len),
        .issue_i      (issue),
        .ack_i        (mem_hs && in_burst),
        .cur_addr_o   (cur_addr),
        .issue_done_o (issue_done),
        .ack_last_o   (ack_last)
    );

    // Burst FSM with registered request, read-return and status outputs.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
            mem_wr_rd_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            m_rdata_q   <= '0;
            m_rvalid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            m_rvalid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (!cmd_legal) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= cmd_wr_rd ? ST_WR : ST_RD;
                        end
                    end
                end
                ST_WR, ST_RD: begin
                    // The last acknowledge can never coincide with a new
                    // issue: every beat has already been issued by then.
                    if (mem_hs && ack_last) begin
                        state_q     <= ST_DONE;
                        mem_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end else if (issue) begin
                        mem_valid_q <= 1'b1;
                        mem_wr_rd_q <= (state_q == ST_WR);
                        mem_addr_q  <= cur_addr;
                        if (state_q == ST_WR) begin
                            mem_wdata_q <= s_wdata;
                        end
                    end else if (mem_hs) begin
                        mem_valid_q <= 1'b0;
                    end
                    if ((state_q == ST_RD) && mem_hs) begin
                        m_rdata_q  <= mem_rdata;
                        m_rvalid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_wr_rd = mem_wr_rd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign m_rdata   = m_rdata_q;
    assign m_rvalid  = m_rvalid_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
